// File: rtl/spec_upload_packer.sv
// Buffers complete power-spectrum frames in a FIFO and replays each one on the ADQ
// user-logic output as: one header word, N_BINS data words, one idle gap cycle.
module spec_upload_packer #(
    parameter int unsigned N_BINS    = 512,
    parameter int unsigned IDX_W     = 9,
    parameter int unsigned FIFO_AW   = 10,
    parameter logic [15:0] HDR_MAGIC = 16'hA5C3
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             enable_i,
    input  logic             spec_valid_i,
    input  logic [IDX_W-1:0] spec_index_i,
    input  logic [31:0]      spec_data_i,
    output logic [15:0]      y0_o,
    output logic [15:0]      y0z_o,
    output logic [3:0]       trigger_vector_o,
    output logic             data_valid_o,
    output logic [15:0]      frame_cnt_o,
    output logic             overflow_o,
    output logic             seq_err_o,
    output logic             busy_o
);
    localparam int unsigned      Depth   = 2 ** FIFO_AW;
    localparam int unsigned      CntW    = FIFO_AW + 1;
    localparam logic [CntW-1:0]  DepthC  = CntW'(Depth);
    localparam logic [CntW-1:0]  NBinsC  = CntW'(N_BINS);
    localparam logic [IDX_W-1:0] LastBin = IDX_W'(N_BINS - 1);

    typedef enum logic [1:0] {StIdle, StHdr, StData, StGap} state_e;

    logic [31:0]      mem [Depth];
    logic [CntW-1:0]  wr_ptr_q, rd_ptr_q, fifo_cnt, pend_q;
    logic             in_frame_q, drop_q, overflow_q, seq_err_q;
    logic [IDX_W-1:0] wcnt_q, exp_idx_q, cur_bin;
    logic             accept, room, wr_en, frame_done;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] dcnt_q, dcnt_d;
    logic [15:0]      frame_cnt_q, frame_cnt_d;
    logic [15:0]      y0_q, y0_d, y0z_q, y0z_d;
    logic [3:0]       trig_q, trig_d;
    logic             dv_q, dv_d;
    logic             rd_en, pend_dec;
    logic [31:0]      rd_word;

    assign accept   = enable_i & spec_valid_i;
    assign fifo_cnt = wr_ptr_q - rd_ptr_q;
    // Room is judged once at frame start so a frame is either kept whole or dropped whole.
    assign room     = (DepthC - fifo_cnt) >= NBinsC;
    assign wr_en    = accept & (in_frame_q | ((spec_index_i == '0) & room));
    assign cur_bin  = in_frame_q ? wcnt_q : '0;
    assign frame_done = wr_en & (cur_bin == LastBin);
    assign rd_word  = mem[rd_ptr_q[FIFO_AW-1:0]];

    // Input framing: frame start/drop decisions, bin counting and sticky error flags.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            in_frame_q <= 1'b0;
            drop_q     <= 1'b0;
            wcnt_q     <= '0;
            exp_idx_q  <= '0;
            overflow_q <= 1'b0;
            seq_err_q  <= 1'b0;
        end else if (accept) begin
            if (!in_frame_q) begin
                if (spec_index_i == '0) begin
                    if (room) begin
                        in_frame_q <= !frame_done;
                        drop_q     <= 1'b0;
                        wcnt_q     <= IDX_W'(1);
                        exp_idx_q  <= IDX_W'(1);
                    end else begin
                        drop_q     <= 1'b1;
                        overflow_q <= 1'b1;
                    end
                end else if (!drop_q) begin
                    // Stray bins of a dropped frame are expected; anything else is an error.
                    seq_err_q <= 1'b1;
                end
            end else begin
                if (spec_index_i != exp_idx_q) seq_err_q <= 1'b1;
                exp_idx_q <= spec_index_i + IDX_W'(1);
                wcnt_q    <= wcnt_q + IDX_W'(1);
                if (frame_done) in_frame_q <= 1'b0;
            end
        end
    end

    // FIFO storage; contents need no reset since pointers define validity.
    always_ff @(posedge clk_i) begin
        if (wr_en) mem[wr_ptr_q[FIFO_AW-1:0]] <= spec_data_i;
    end

    // FIFO pointers and count of complete frames waiting for upload.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            pend_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_q + CntW'(wr_en);
            rd_ptr_q <= rd_ptr_q + CntW'(rd_en);
            pend_q   <= pend_q + CntW'(frame_done) - CntW'(pend_dec);
        end
    end

    // Output FSM next state and next values of the registered outputs.
    always_comb begin
        state_d     = state_q;
        dcnt_d      = dcnt_q;
        frame_cnt_d = frame_cnt_q;
        y0_d        = '0;
        y0z_d       = '0;
        trig_d      = '0;
        dv_d        = 1'b0;
        rd_en       = 1'b0;
        pend_dec    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (pend_q != '0) state_d = StHdr;
            end
            StHdr: begin
                y0_d    = HDR_MAGIC;
                y0z_d   = frame_cnt_q;
                trig_d  = 4'b0001;
                dv_d    = 1'b1;
                dcnt_d  = '0;
                state_d = StData;
            end
            StData: begin
                y0_d   = rd_word[31:16];
                y0z_d  = rd_word[15:0];
                dv_d   = 1'b1;
                rd_en  = 1'b1;
                dcnt_d = dcnt_q + IDX_W'(1);
                if (dcnt_q == LastBin) state_d = StGap;
            end
            StGap: begin
                pend_dec    = 1'b1;
                frame_cnt_d = frame_cnt_q + 16'd1;
                state_d     = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Output FSM state and output registers.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= StIdle;
            dcnt_q      <= '0;
            frame_cnt_q <= '0;
            y0_q        <= '0;
            y0z_q       <= '0;
            trig_q      <= '0;
            dv_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            dcnt_q      <= dcnt_d;
            frame_cnt_q <= frame_cnt_d;
            y0_q        <= y0_d;
            y0z_q       <= y0z_d;
            trig_q      <= trig_d;
            dv_q        <= dv_d;
        end
    end

    assign y0_o             = y0_q;
    assign y0z_o            = y0z_q;
    assign trigger_vector_o = trig_q;
    assign data_valid_o     = dv_q;
    assign frame_cnt_o      = frame_cnt_q;
    assign overflow_o       = overflow_q;
    assign seq_err_o        = seq_err_q;
    assign busy_o           = (state_q != StIdle) | in_frame_q;

endmodule
